// File: rtl/pc_fetch_ctrl.sv
// Instruction-fetch controller: keeps the PC, issues one request at a time to
// instruction memory, and fills the IF/ID register. Handles stalls, branches and flush.
//
// state   | meaning
// IDLE    | out of reset, no request issued yet
// REQ     | request outstanding at imem_addr; accepted data goes into IF/ID
// HOLD    | stalled, request withdrawn, IF/ID frozen
// DISCARD | branch taken while a request was in flight; its data will be dropped
module pc_fetch_ctrl #(
    parameter int                 WIDTH    = 64,
    parameter logic [WIDTH-1:0]   RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             br_taken,
    input  logic [WIDTH-1:0] br_target,
    input  logic             stall,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic             if_valid,
    output logic [WIDTH-1:0] if_pc,
    output logic [31:0]      if_instr,
    output logic             flush
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD, DISCARD} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] br_aligned;
    logic [WIDTH-1:0] pc_inc;

    assign br_aligned = br_target & ~WIDTH'(3);
    assign pc_inc     = pc + WIDTH'(4);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = REQ;
            REQ: begin
                if (br_taken) begin
                    state_nxt = imem_ack ? REQ : DISCARD;
                end else if (imem_ack && stall) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (!stall) begin
                    state_nxt = REQ;
                end
            end
            DISCARD: begin
                if (!br_taken && imem_ack) begin
                    state_nxt = REQ;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        imem_req = (state == REQ) || (state == DISCARD);
    end

    // Datapath: pc tracks where fetch continues, imem_addr is what is on the bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc        <= RESET_PC;
            imem_addr <= RESET_PC;
            if_valid  <= 1'b0;
            if_pc     <= '0;
            if_instr  <= '0;
            flush     <= 1'b0;
        end else begin
            flush <= br_taken && (state != IDLE);
            case (state)
                REQ: begin
                    if (br_taken) begin
                        pc       <= br_aligned;
                        if_valid <= 1'b0;
                        if (imem_ack) begin
                            imem_addr <= br_aligned;
                        end
                    end else if (imem_ack && !stall) begin
                        if_valid  <= 1'b1;
                        if_pc     <= imem_addr;
                        if_instr  <= imem_rdata;
                        pc        <= pc_inc;
                        imem_addr <= pc_inc;
                    end else if (!imem_ack && !stall) begin
                        if_valid <= 1'b0;
                    end
                end
                HOLD: begin
                    if (br_taken) begin
                        pc       <= br_aligned;
                        if_valid <= 1'b0;
                        if (!stall) begin
                            imem_addr <= br_aligned;
                        end
                    end else if (!stall) begin
                        imem_addr <= pc;
                    end
                end
                DISCARD: begin
                    // Old request stays on the bus until acked; only the redirect target moves.
                    if (br_taken) begin
                        pc       <= br_aligned;
                        if_valid <= 1'b0;
                    end else if (imem_ack) begin
                        imem_addr <= pc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed scenarios against fixed values,
// then randomized traffic against a transaction-level fetch model.
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        br_taken = 1'b0;
    logic [63:0] br_target = '0;
    logic        stall = 1'b0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        if_valid;
    logic [63:0] if_pc;
    logic [31:0] if_instr;
    logic        flush;

    logic        hi_req;
    logic [63:0] hi_addr;
    logic        hi_valid;
    logic [63:0] hi_pc;
    logic [31:0] hi_instr;
    logic        hi_flush;

    int          total = 0;
    int          bad = 0;
    int          ws = 0;
    bit          rand_ack = 1'b0;
    int          wcnt = 0;
    logic [31:0] salt = '0;

    // reference model: fetch progress expressed as flags plus addresses
    bit          m_live, m_paused, m_squash, m_valid, m_flush;
    logic [63:0] m_next, m_addr, m_ipc;
    logic [31:0] m_instr;

    always #5 clk = ~clk;

    pc_fetch_ctrl #(.WIDTH(64), .RESET_PC(64'h0)) dut (
        .clk(clk), .reset(reset), .br_taken(br_taken), .br_target(br_target),
        .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .if_valid(if_valid),
        .if_pc(if_pc), .if_instr(if_instr), .flush(flush)
    );

    pc_fetch_ctrl #(.WIDTH(64), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_hi (
        .clk(clk), .reset(reset), .br_taken(1'b0), .br_target(64'h0),
        .stall(1'b0), .imem_req(hi_req), .imem_addr(hi_addr),
        .imem_ack(hi_req), .imem_rdata(hi_addr[31:0]), .if_valid(hi_valid),
        .if_pc(hi_pc), .if_instr(hi_instr), .flush(hi_flush)
    );

    task automatic model_step(input logic rst, input logic br, input logic [63:0] tgt,
                              input logic st, input logic ack, input logic [31:0] rd);
        logic [63:0] t;
        t = {tgt[63:2], 2'b00};
        if (rst) begin
            m_live = 0; m_paused = 0; m_squash = 0; m_valid = 0; m_flush = 0;
            m_next = '0; m_addr = '0; m_ipc = '0; m_instr = '0;
        end else begin
            m_flush = m_live && br;
            if (!m_live) begin
                m_live = 1;
            end else if (br) begin
                m_next  = t;
                m_valid = 0;
                if (m_paused) begin
                    if (!st) begin m_addr = t; m_paused = 0; end
                end else if (!m_squash) begin
                    if (ack) m_addr = t;
                    else m_squash = 1;
                end
            end else if (m_squash) begin
                if (ack) begin m_addr = m_next; m_squash = 0; end
            end else if (m_paused) begin
                if (!st) begin m_addr = m_next; m_paused = 0; end
            end else if (ack && !st) begin
                m_valid = 1; m_ipc = m_addr; m_instr = rd;
                m_addr  = m_addr + 64'd4;
                m_next  = m_addr;
            end else if (ack) begin
                m_paused = 1;
            end else if (!st) begin
                m_valid = 0;
            end
        end
    endtask

    // One clock: drive inputs at the negedge, advance, return at the next negedge.
    task automatic cycle(input logic rst, input logic br, input logic [63:0] tgt, input logic st);
        logic req_now;
        reset = rst; br_taken = br; br_target = tgt; stall = st;
        req_now = (imem_req === 1'b1);
        if (rand_ack) imem_ack = req_now && ($urandom_range(0, 2) != 0);
        else          imem_ack = req_now && (wcnt >= ws);
        imem_rdata = imem_addr[31:0] ^ salt;
        model_step(rst, br, tgt, st, imem_ack, imem_rdata);
        @(posedge clk);
        if (rst || imem_ack || !req_now) wcnt = 0;
        else wcnt++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
    endtask

    task automatic test_reset();
        ws = 0; salt = '0; rand_ack = 0;
        do_reset();
        total++;
        if (imem_req !== 1'b0 || imem_addr !== 64'h0 || if_valid !== 1'b0 ||
            if_pc !== 64'h0 || if_instr !== 32'h0 || flush !== 1'b0)
        begin
            bad++;
            $display("FAIL reset_state got req=%b addr=%h v=%b pc=%h ins=%h fl=%b exp all zero",
                     imem_req, imem_addr, if_valid, if_pc, if_instr, flush);
        end
    endtask

    task automatic test_stream();
        ws = 0;
        do_reset();
        for (int k = 1; k <= 6; k++) begin
            cycle(0, 0, 0, 0);
            total++;
            if (imem_req !== 1'b1 || imem_addr !== 64'((k - 1) * 4)) begin
                bad++;
                $display("FAIL stream_addr k=%0d got req=%b addr=%h exp req=1 addr=%h",
                         k, imem_req, imem_addr, 64'((k - 1) * 4));
            end
            total++;
            if (k == 1 ? (if_valid !== 1'b0)
                       : (if_valid !== 1'b1 || if_pc !== 64'((k - 2) * 4) ||
                          if_instr !== 32'((k - 2) * 4))) begin
                bad++;
                $display("FAIL stream_ifid k=%0d got v=%b pc=%h ins=%h exp v=%0d pc=%h",
                         k, if_valid, if_pc, if_instr, k > 1, 64'((k - 2) * 4));
            end
        end
    endtask

    task automatic test_wait();
        ws = 1;
        do_reset();
        for (int k = 1; k <= 7; k++) begin
            logic ev;
            cycle(0, 0, 0, 0);
            ev = (k >= 3) && (k % 2 == 1);
            total++;
            if (imem_addr !== 64'(4 * ((k - 1) / 2)) || if_valid !== ev) begin
                bad++;
                $display("FAIL wait_seq k=%0d got addr=%h v=%b exp addr=%h v=%b",
                         k, imem_addr, if_valid, 64'(4 * ((k - 1) / 2)), ev);
            end
            if (ev) begin
                total++;
                if (if_pc !== 64'(4 * ((k - 3) / 2))) begin
                    bad++;
                    $display("FAIL wait_pc k=%0d got %h exp %h", k, if_pc, 64'(4 * ((k - 3) / 2)));
                end
            end
        end
    endtask

    task automatic test_stall();
        ws = 0;
        do_reset();
        repeat (3) cycle(0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            cycle(0, 0, 0, 1);
            total++;
            if (imem_req !== 1'b0 || imem_addr !== 64'h8 || if_valid !== 1'b1 || if_pc !== 64'h4) begin
                bad++;
                $display("FAIL stall_hold k=%0d got req=%b addr=%h v=%b pc=%h exp req=0 addr=8 v=1 pc=4",
                         k, imem_req, imem_addr, if_valid, if_pc);
            end
        end
        cycle(0, 0, 0, 0);
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 64'h8) begin
            bad++;
            $display("FAIL stall_resume got req=%b addr=%h exp req=1 addr=8", imem_req, imem_addr);
        end
        cycle(0, 0, 0, 0);
        total++;
        if (if_valid !== 1'b1 || if_pc !== 64'h8 || if_instr !== 32'h8 || imem_addr !== 64'hC) begin
            bad++;
            $display("FAIL stall_refetch got v=%b pc=%h ins=%h addr=%h exp v=1 pc=8 ins=8 addr=c",
                     if_valid, if_pc, if_instr, imem_addr);
        end
    endtask

    task automatic test_branch();
        ws = 1;
        do_reset();
        repeat (9) cycle(0, 0, 0, 0);
        total++;
        if (imem_addr !== 64'h10) begin
            bad++;
            $display("FAIL branch_setup got addr=%h exp 10", imem_addr);
        end
        cycle(0, 1, 64'h103, 0);
        total++;
        if (flush !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 64'h10 || if_valid !== 1'b0) begin
            bad++;
            $display("FAIL branch_pending got fl=%b req=%b addr=%h v=%b exp fl=1 req=1 addr=10 v=0",
                     flush, imem_req, imem_addr, if_valid);
        end
        cycle(0, 0, 0, 0);
        total++;
        if (flush !== 1'b0 || imem_addr !== 64'h100 || if_valid !== 1'b0) begin
            bad++;
            $display("FAIL branch_discard got fl=%b addr=%h v=%b exp fl=0 addr=100 v=0",
                     flush, imem_addr, if_valid);
        end
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        total++;
        if (if_valid !== 1'b1 || if_pc !== 64'h100 || if_instr !== 32'h100) begin
            bad++;
            $display("FAIL branch_target got v=%b pc=%h ins=%h exp v=1 pc=100 ins=100",
                     if_valid, if_pc, if_instr);
        end
    endtask

    task automatic test_back_to_back();
        ws = 0;
        do_reset();
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 1, 64'h202, 0);
        total++;
        if (imem_addr !== 64'h200 || if_valid !== 1'b0 || flush !== 1'b1 || imem_req !== 1'b1) begin
            bad++;
            $display("FAIL b2b_first got addr=%h v=%b fl=%b req=%b exp addr=200 v=0 fl=1 req=1",
                     imem_addr, if_valid, flush, imem_req);
        end
        cycle(0, 1, 64'h301, 0);
        total++;
        if (imem_addr !== 64'h300 || if_valid !== 1'b0 || flush !== 1'b1) begin
            bad++;
            $display("FAIL b2b_second got addr=%h v=%b fl=%b exp addr=300 v=0 fl=1",
                     imem_addr, if_valid, flush);
        end
        cycle(0, 0, 0, 0);
        total++;
        if (if_valid !== 1'b1 || if_pc !== 64'h300 || flush !== 1'b0 || imem_addr !== 64'h304) begin
            bad++;
            $display("FAIL b2b_land got v=%b pc=%h fl=%b addr=%h exp v=1 pc=300 fl=0 addr=304",
                     if_valid, if_pc, flush, imem_addr);
        end
        cycle(0, 0, 0, 1);
        cycle(0, 1, 64'h405, 1);
        total++;
        if (imem_req !== 1'b0 || flush !== 1'b1 || if_valid !== 1'b0 || imem_addr !== 64'h304) begin
            bad++;
            $display("FAIL hold_branch got req=%b fl=%b v=%b addr=%h exp req=0 fl=1 v=0 addr=304",
                     imem_req, flush, if_valid, imem_addr);
        end
        cycle(0, 0, 0, 0);
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 64'h404 || flush !== 1'b0) begin
            bad++;
            $display("FAIL hold_release got req=%b addr=%h fl=%b exp req=1 addr=404 fl=0",
                     imem_req, imem_addr, flush);
        end
    endtask

    task automatic test_wrap();
        ws = 0;
        do_reset();
        total++;
        if (hi_addr !== 64'hFFFF_FFFF_FFFF_FFFC || hi_req !== 1'b0) begin
            bad++;
            $display("FAIL wrap_reset got addr=%h req=%b exp fffffffffffffffc req=0", hi_addr, hi_req);
        end
        cycle(0, 0, 0, 0);
        total++;
        if (hi_addr !== 64'hFFFF_FFFF_FFFF_FFFC || hi_req !== 1'b1) begin
            bad++;
            $display("FAIL wrap_first got addr=%h req=%b exp fffffffffffffffc req=1", hi_addr, hi_req);
        end
        cycle(0, 0, 0, 0);
        total++;
        if (hi_addr !== 64'h0 || hi_valid !== 1'b1 || hi_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin
            bad++;
            $display("FAIL wrap_zero got addr=%h v=%b pc=%h exp addr=0 v=1 pc=fffffffffffffffc",
                     hi_addr, hi_valid, hi_pc);
        end
        cycle(0, 0, 0, 0);
        total++;
        if (hi_addr !== 64'h4 || hi_pc !== 64'h0) begin
            bad++;
            $display("FAIL wrap_four got addr=%h pc=%h exp addr=4 pc=0", hi_addr, hi_pc);
        end
    endtask

    task automatic test_reset_mid();
        ws = 1;
        do_reset();
        repeat (5) cycle(0, 0, 0, 0);
        cycle(1, 1, 64'h500, 1);
        total++;
        if (imem_req !== 1'b0 || imem_addr !== 64'h0 || if_valid !== 1'b0 ||
            if_pc !== 64'h0 || if_instr !== 32'h0 || flush !== 1'b0)
        begin
            bad++;
            $display("FAIL reset_mid got req=%b addr=%h v=%b pc=%h ins=%h fl=%b exp all zero",
                     imem_req, imem_addr, if_valid, if_pc, if_instr, flush);
        end
        cycle(0, 0, 0, 0);
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin
            bad++;
            $display("FAIL reset_refetch got req=%b addr=%h exp req=1 addr=0", imem_req, imem_addr);
        end
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        total++;
        if (if_valid !== 1'b1 || if_pc !== 64'h0) begin
            bad++;
            $display("FAIL reset_first_instr got v=%b pc=%h exp v=1 pc=0", if_valid, if_pc);
        end
    endtask

    task automatic test_random();
        rand_ack = 1;
        salt = $urandom;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            logic        r, b, s;
            logic [63:0] t;
            r = ($urandom_range(0, 199) == 0);
            b = ($urandom_range(0, 7) == 0);
            s = ($urandom_range(0, 3) == 0);
            t = {$urandom, $urandom};
            cycle(r, b, t, s);
            total++;
            if (imem_req !== (m_live && !m_paused) || imem_addr !== m_addr ||
                if_valid !== m_valid || flush !== m_flush ||
                (m_valid && (if_pc !== m_ipc || if_instr !== m_instr)))
            begin
                bad++;
                $display("FAIL random n=%0d got req=%b addr=%h v=%b pc=%h ins=%h fl=%b exp req=%b addr=%h v=%b pc=%h ins=%h fl=%b",
                         n, imem_req, imem_addr, if_valid, if_pc, if_instr, flush,
                         m_live && !m_paused, m_addr, m_valid, m_ipc, m_instr, m_flush);
            end
        end
        rand_ack = 0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_wait();
        test_stall();
        test_branch();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 64'h0: PC value loaded on reset.
REQ-002 Parameter WIDTH, default 64: PC and address width.
REQ-003 CLK  in  1  single clock; all state updates on the rising edge.
REQ-004 RESET  in  1  synchronous, active-high reset.
REQ-005 br_taken  in  1  one-cycle pulse: a resolved branch is taken.
REQ-006 br_target  in  WIDTH  branch target, valid while br_taken=1.
REQ-007 stall  in  1  hazard-unit stall request.
REQ-008 imem_req  out  1  instruction-memory request.
REQ-009 imem_addr  out  WIDTH  request address, registered.
REQ-010 imem_ack  in  1  memory accepts the request and returns data this cycle.
REQ-011 imem_rdata  in  32  instruction word, valid while imem_ack=1.
REQ-012 if_valid  out  1  IF/ID register holds a valid instruction.
REQ-013 if_pc  out  WIDTH  PC of the instruction held in IF/ID.
REQ-014 if_instr  out  32  instruction held in IF/ID.
REQ-015 flush  out  1  one-cycle pulse telling downstream stages to squash.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, REQ, HOLD and DISCARD.
REQ-017 Internal pc register SHALL advance by pc+4 modulo 2^WIDTH; wrap from all-ones-minus-3 to 0 is silent.
REQ-018 The low 2 bits of br_target SHALL be forced to 0 when loaded.
REQ-019 IDLE: imem_req=0; imem_ack ignored; next state REQ unconditionally.
REQ-020 REQ: imem_req=1; imem_addr SHALL hold the latched request address stable until imem_ack.
REQ-021 REQ, imem_ack=1, stall=0, br_taken=0: load if_instr<=imem_rdata, if_pc<=imem_addr and if_valid<=1; pc and imem_addr <= pc+4; remain in REQ (one instruction per cycle with zero-wait memory).
REQ-022 REQ, imem_ack=1, stall=1: drop the returned data, leave pc unchanged, IF/ID holds, go to HOLD.
REQ-023 REQ, imem_ack=0, stall=1: keep the request asserted; evaluate stall again at ack.
REQ-024 HOLD: imem_req=0; IF/ID holds; when stall=0, imem_addr<=pc and go to REQ.
REQ-025 br_taken=1 in any non-IDLE state: pc<=br_target; if_valid<=0; flush=1 on the next cycle for exactly one cycle; branch overrides stall.
REQ-026 br_taken in REQ with no ack, or in DISCARD: go or stay in DISCARD; imem_req stays 1 at the old address; the latest br_target wins.
REQ-027 DISCARD: on imem_ack, drop the data, imem_addr<=pc, go to REQ.
REQ-028 br_taken with imem_ack in the same cycle in REQ: drop the ack data, imem_addr<=target, stay in REQ.
REQ-029 br_taken in HOLD: load the target, flush, and stay in HOLD until stall=0.
REQ-030 br_taken in IDLE: ignored.

Reset
REQ-031 RESET=1 at an edge SHALL set: state=IDLE, pc=RESET_PC, imem_addr=RESET_PC, imem_req=0, if_valid=0, if_pc=0, if_instr=0, flush=0.
REQ-032 Reset mid-transaction SHALL abandon any outstanding request; the instruction memory is reset together with this block.
REQ-033 Reset SHALL take priority over every other input in the same cycle.

Verification
REQ-034 Setup: RESET_PC=0, ack tied to req, stall=0, rdata=addr[31:0]. Stimulus: release reset. Required: imem_addr 0,4,8,12 on consecutive cycles; if_valid first high 2 cycles after reset release with if_pc=0.
REQ-035 Stimulus: 1-wait-state memory (ack one cycle after req). Required: imem_addr held 2 cycles each; if_pc 0,4,8 with if_valid low between.
REQ-036 Stimulus: stall=1 for 3 cycles during streaming at pc=8. Required: data at 8 dropped; imem_req=0 in HOLD; IF/ID keeps pc=4; fetch resumes at 8.
REQ-037 Stimulus: br_taken, br_target=0x103 while a request to 0x10 is pending. Required: ack for 0x10 discarded; flush pulses 1 cycle; next imem_addr=0x100.
REQ-038 Stimulus: RESET_PC=64'hFFFF_FFFF_FFFF_FFFC, zero-wait memory. Required: imem_addr sequence FFF..FC then 0 then 4.
REQ-039 Stimulus: RESET asserted during a wait-state request. Required: all outputs at reset values the next cycle; refetch from RESET_PC.
